// File: rtl/rc4_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : rc4_decrypt
// Purpose  : RC4 PRGA keystream generator; XORs each ROM byte with keystream
//            into the decrypted RAM while swapping S entries.
// Revision : 1.0  initial release
// ============================================================================
module rc4_decrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] s_q,
  input  logic [7:0] rom_q,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wen,
  output logic [7:0] rom_address,
  output logic [7:0] ram_address,
  output logic [7:0] ram_data,
  output logic       ram_wen,
  output logic       decrypt_mem_handler,
  output logic       finish
);

  localparam logic [3:0] c_IDLE   = 4'd0;
  localparam logic [3:0] c_INC    = 4'd1;
  localparam logic [3:0] c_ADDR_I = 4'd2;
  localparam logic [3:0] c_WAIT_I = 4'd3;
  localparam logic [3:0] c_LD_I   = 4'd4;
  localparam logic [3:0] c_ADDR_J = 4'd5;
  localparam logic [3:0] c_WAIT_J = 4'd6;
  localparam logic [3:0] c_LD_J   = 4'd7;
  localparam logic [3:0] c_WR_I   = 4'd8;
  localparam logic [3:0] c_WR_J   = 4'd9;
  localparam logic [3:0] c_ADDR_F = 4'd10;
  localparam logic [3:0] c_WAIT_F = 4'd11;
  localparam logic [3:0] c_LD_F   = 4'd12;
  localparam logic [3:0] c_WR_OUT = 4'd13;
  localparam logic [3:0] c_NEXT   = 4'd14;
  localparam logic [3:0] c_DONE   = 4'd15;

  localparam logic [7:0] c_LAST_K = 8'(MSG_LEN - 1);

  logic [3:0] r_state;
  logic [7:0] r_i;
  logic [7:0] r_j;
  logic [7:0] r_k;
  logic [7:0] r_si;
  logic [7:0] r_sj;
  logic [7:0] r_f;
  logic [7:0] r_enc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state             <= c_IDLE;
      r_i                 <= 8'd0;
      r_j                 <= 8'd0;
      r_k                 <= 8'd0;
      r_si                <= 8'd0;
      r_sj                <= 8'd0;
      r_f                 <= 8'd0;
      r_enc               <= 8'd0;
      s_address           <= 8'd0;
      s_data              <= 8'd0;
      s_wen               <= 1'b0;
      rom_address         <= 8'd0;
      ram_address         <= 8'd0;
      ram_data            <= 8'd0;
      ram_wen             <= 1'b0;
      decrypt_mem_handler <= 1'b0;
      finish              <= 1'b0;
    end else begin
      // Write strobes are single-cycle pulses raised only by the write states.
      s_wen   <= 1'b0;
      ram_wen <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            finish              <= 1'b0;
            decrypt_mem_handler <= 1'b1;
            r_i                 <= 8'd0;
            r_j                 <= 8'd0;
            r_k                 <= 8'd0;
            r_state             <= c_INC;
          end
        end
        c_INC: begin
          r_i     <= r_i + 8'd1;
          r_state <= c_ADDR_I;
        end
        c_ADDR_I: begin
          s_address <= r_i;
          r_state   <= c_WAIT_I;
        end
        c_WAIT_I: r_state <= c_LD_I;
        c_LD_I: begin
          r_si    <= s_q;
          r_j     <= r_j + s_q;
          r_state <= c_ADDR_J;
        end
        c_ADDR_J: begin
          s_address <= r_j;
          r_state   <= c_WAIT_J;
        end
        c_WAIT_J: r_state <= c_LD_J;
        c_LD_J: begin
          r_sj    <= s_q;
          r_state <= c_WR_I;
        end
        // When i==j the second write lands on the same entry and leaves si there.
        c_WR_I: begin
          s_address <= r_i;
          s_data    <= r_sj;
          s_wen     <= 1'b1;
          r_state   <= c_WR_J;
        end
        c_WR_J: begin
          s_address <= r_j;
          s_data    <= r_si;
          s_wen     <= 1'b1;
          r_state   <= c_ADDR_F;
        end
        c_ADDR_F: begin
          s_address   <= r_si + r_sj;
          rom_address <= r_k;
          r_state     <= c_WAIT_F;
        end
        c_WAIT_F: r_state <= c_LD_F;
        c_LD_F: begin
          r_f     <= s_q;
          r_enc   <= rom_q;
          r_state <= c_WR_OUT;
        end
        c_WR_OUT: begin
          ram_address <= r_k;
          ram_data    <= r_f ^ r_enc;
          ram_wen     <= 1'b1;
          r_state     <= c_NEXT;
        end
        c_NEXT: begin
          if (r_k == c_LAST_K) begin
            r_state <= c_DONE;
          end else begin
            r_k     <= r_k + 8'd1;
            r_state <= c_INC;
          end
        end
        c_DONE: begin
          finish              <= 1'b1;
          decrypt_mem_handler <= 1'b0;
          r_state             <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rc4_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc4_decrypt
// Purpose  : Scoreboard bench for rc4_decrypt (three instances: MSG_LEN 2,1,32)
// Revision : 1.0  initial release
// ============================================================================
module tb_rc4_decrypt;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a [3];
  logic [7:0] s_address_a [3];
  logic [7:0] s_data_a [3];
  logic       s_wen_a [3];
  logic [7:0] rom_address_a [3];
  logic [7:0] ram_address_a [3];
  logic [7:0] ram_data_a [3];
  logic       ram_wen_a [3];
  logic       handler_a [3];
  logic       finish_a [3];

  logic [7:0] s_q;
  logic [7:0] rom_q;
  logic [7:0] s_mem [256];
  logic [7:0] rom_mem [256];
  logic [7:0] ram_mem [256];
  logic [7:0] load_buf [256];
  logic       load_req;
  logic [7:0] s_addr_r;
  logic [7:0] rom_addr_r;
  int         sel;

  logic [7:0]  ms [256];
  logic [17:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rc4_decrypt #(.MSG_LEN(g == 0 ? 2 : (g == 1 ? 1 : 32))) u_dut (
      .clk                 (clk),
      .reset               (reset),
      .start               (start_a[g]),
      .s_q                 (s_q),
      .rom_q               (rom_q),
      .s_address           (s_address_a[g]),
      .s_data              (s_data_a[g]),
      .s_wen               (s_wen_a[g]),
      .rom_address         (rom_address_a[g]),
      .ram_address         (ram_address_a[g]),
      .ram_data            (ram_data_a[g]),
      .ram_wen             (ram_wen_a[g]),
      .decrypt_mem_handler (handler_a[g]),
      .finish              (finish_a[g])
    );
  end

  // Shared memories with registered address, routed to the selected instance.
  always @(posedge clk) begin
    s_addr_r   <= s_address_a[sel];
    rom_addr_r <= rom_address_a[sel];
    if (load_req) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= load_buf[x];
    end else if (s_wen_a[sel]) begin
      s_mem[s_address_a[sel]] <= s_data_a[sel];
    end
    if (ram_wen_a[sel]) ram_mem[ram_address_a[sel]] <= ram_data_a[sel];
  end
  assign s_q   = s_mem[s_addr_r];
  assign rom_q = rom_mem[rom_addr_r];

  // Monitor: every RAM write must match the next expected entry.
  always @(negedge clk) begin
    logic [17:0] e;
    logic [17:0] a;
    if (ram_wen_a[sel]) begin
      checks++;
      a = {sel[1:0], ram_address_a[sel], ram_data_a[sel]};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ram_write unexpected: inst %0d addr %0d data %02h, none expected",
                 sel, ram_address_a[sel], ram_data_a[sel]);
      end else begin
        e = exp_q.pop_front();
        if (e != a) begin
          errors++;
          $display("FAIL ram_write: got inst %0d addr %0d data %02h, expected inst %0d addr %0d data %02h",
                   a[17:16], a[15:8], a[7:0], e[17:16], e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic load_s();
    for (int x = 0; x < 256; x++) load_buf[x] = ms[x];
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic load_identity();
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    load_s();
  endtask

  // Reference RC4 PRGA over the model copy of S.
  task automatic model_run(input int g, input int len);
    int i = 0, j = 0;
    logic [7:0] t, f;
    for (int k = 0; k < len; k++) begin
      i = (i + 1) % 256;
      j = (j + ms[i]) % 256;
      t = ms[i]; ms[i] = ms[j]; ms[j] = t;
      f = ms[(ms[i] + ms[j]) % 256];
      exp_q.push_back({2'(g), 8'(k), f ^ rom_mem[k]});
    end
  endtask

  task automatic check_s(input string name);
    int bad = 0;
    int first = -1;
    for (int x = 0; x < 256; x++)
      if (s_mem[x] != ms[x]) begin
        bad++;
        if (first < 0) first = x;
      end
    if (bad != 0) $display("  first S difference at index %0d: got %02h want %02h", first, s_mem[first], ms[first]);
    chk(name, bad, 0);
  endtask

  task automatic run_inst(input int g, input int len, input int busy_at, input string tag);
    int cyc = 0, swc = 0, rwc = 0;
    int limit = 14 * len + 40;
    bit done = 0;
    logic last_h = 1'b0;
    sel = g;
    @(negedge clk); start_a[g] = 1'b1;
    @(negedge clk); start_a[g] = 1'b0;
    last_h = handler_a[g];
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
      start_a[g] = (busy_at != 0 && cyc == busy_at);
      if (s_wen_a[g]) swc++;
      if (ram_wen_a[g]) rwc++;
      if (finish_a[g]) begin
        done = 1;
        chk({tag, "_finish_cycle"}, cyc, 14 * len + 1);
        chk({tag, "_handler_falls"}, int'(handler_a[g]), 0);
        chk({tag, "_handler_before"}, int'(last_h), 1);
      end
      last_h = handler_a[g];
    end
    start_a[g] = 1'b0;
    if (!done) chk({tag, "_finish_timeout"}, cyc, 14 * len + 1);
    chk({tag, "_s_wen_cycles"}, swc, 2 * len);
    chk({tag, "_ram_wen_cycles"}, rwc, len);
    repeat (2) @(negedge clk);
    chk({tag, "_finish_sticky"}, int'(finish_a[g]), 1);
  endtask

  initial begin
    int r, leak;
    logic [7:0] t;
    reset = 1'b1;
    load_req = 1'b0;
    sel = 0;
    for (int g = 0; g < 3; g++) start_a[g] = 1'b0;
    for (int x = 0; x < 256; x++) rom_mem[x] = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++)
      chk($sformatf("reset_outputs_inst%0d", g),
          int'({s_address_a[g], s_data_a[g], rom_address_a[g], ram_address_a[g], ram_data_a[g],
                s_wen_a[g], ram_wen_a[g], handler_a[g], finish_a[g]} != '0), 0);

    // Identity S, two bytes
    rom_mem[0] = 8'hA5; rom_mem[1] = 8'h5A;
    load_identity();
    model_run(0, 2);
    run_inst(0, 2, 0, "ident");
    chk("ident_ram0", int'(ram_mem[0]), 'hA7);
    chk("ident_ram1", int'(ram_mem[1]), 'h5F);
    chk("ident_s2", int'(s_mem[2]), 'h03);
    chk("ident_s3", int'(s_mem[3]), 'h02);
    check_s("ident_s_final");

    // j wraps to 0xFF and si+sj wraps to 0
    rom_mem[0] = 8'h3C;
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    ms[1] = 8'hFF; ms[255] = 8'h01;
    load_s();
    model_run(1, 1);
    run_inst(1, 1, 0, "wrap");
    chk("wrap_ram0", int'(ram_mem[0]), 'h3C);
    chk("wrap_s1", int'(s_mem[1]), 'h01);
    chk("wrap_s255", int'(s_mem[255]), 'hFF);

    // Reset while the FSM sits in WR_I of byte 0
    rom_mem[0] = 8'hA5; rom_mem[1] = 8'h5A;
    load_identity();
    sel = 0;
    @(negedge clk); start_a[0] = 1'b1;
    @(negedge clk); start_a[0] = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort_outputs_zero",
        int'({s_address_a[0], s_data_a[0], rom_address_a[0], ram_address_a[0], ram_data_a[0],
              s_wen_a[0], ram_wen_a[0], handler_a[0], finish_a[0]} != '0), 0);
    leak = 0;
    repeat (40) begin
      @(negedge clk);
      if (s_wen_a[0] || ram_wen_a[0] || finish_a[0]) leak++;
    end
    chk("abort_no_activity", leak, 0);
    check_s("abort_s_unchanged");
    model_run(0, 2);
    run_inst(0, 2, 0, "rerun");
    chk("rerun_ram0", int'(ram_mem[0]), 'hA7);
    chk("rerun_ram1", int'(ram_mem[1]), 'h5F);
    check_s("rerun_s_final");

    // Extra start pulse during WAIT_J must be ignored
    load_identity();
    model_run(0, 2);
    run_inst(0, 2, 5, "busy");
    check_s("busy_s_final");

    // Random permutation, 32 random bytes
    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      r = int'($urandom_range(x, 0));
      t = ms[x]; ms[x] = ms[r]; ms[r] = t;
    end
    for (int x = 0; x < 32; x++) rom_mem[x] = 8'($urandom);
    load_s();
    model_run(2, 32);
    run_inst(2, 32, 0, "rand");
    check_s("rand_s_final");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rc4_decrypt.md
Name: rc4_decrypt

Overview:
- RC4 keystream generator and decryptor; runs after the key-schedule shuffle has left the 256-byte S memory permuted.
- Owns the S-memory port and walks the message:
  - generates one keystream byte per message byte, swapping S entries as it goes;
  - reads the encrypted byte from the message ROM;
  - writes the XOR result to the decrypted-message RAM.
- Raises finish when all bytes are written; the top-level FSM then releases the memory mux.

Parameters:
MSG_LEN, 32, number of message bytes processed (1..256).

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a run when idle
s_q  input  8  S memory read data
rom_q  input  8  encrypted-message ROM read data
s_address  output  8  S memory address
s_data  output  8  S memory write data
s_wen  output  1  S memory write enable
rom_address  output  8  message ROM address
ram_address  output  8  decrypted RAM address
ram_data  output  8  decrypted RAM write data
ram_wen  output  1  decrypted RAM write enable
decrypt_mem_handler  output  1  high while block owns S/ROM/RAM ports
finish  output  1  run complete (sticky)

Behaviour:
- Single clock, synchronous active-high reset.
- Reset:
  - state IDLE; i, j and byte counter k cleared.
  - All outputs 0.
  - Reset mid-run aborts immediately; no further writes occur.
- Memory model: all memories have a registered address and one-cycle read. Every read uses three states:
  - ADDR: registers the address;
  - WAIT: holds the address;
  - LD: samples q.
- All outputs are registered. s_wen and ram_wen are high only in their write states, for exactly one cycle each.
- Arithmetic: i, j, k, and si+sj are all 8-bit modulo 256. Carries are discarded.
- States, one cycle each:
  - IDLE: on start, clear finish, set decrypt_mem_handler=1, go to INC. start is ignored in all other states.
  - INC: i <= i+1.
  - ADDR_I: s_address <= i.
  - WAIT_I.
  - LD_I: si <= s_q; j <= j+s_q.
  - ADDR_J: s_address <= j.
  - WAIT_J.
  - LD_J: sj <= s_q.
  - WR_I: s_address <= i; s_data <= sj; s_wen=1.
  - WR_J: s_address <= j; s_data <= si; s_wen=1.
  - ADDR_F: s_wen=0; s_address <= si+sj; rom_address <= k.
  - WAIT_F.
  - LD_F: f <= s_q; enc <= rom_q.
  - WR_OUT: ram_address <= k; ram_data <= f^enc; ram_wen=1.
  - NEXT: ram_wen=0. If k==MSG_LEN-1 go to DONE; else k <= k+1 and go to INC.
  - DONE: finish=1; decrypt_mem_handler=0; return to IDLE. finish stays high until the next start or reset.
- Timing:
  - 14 cycles per byte.
  - finish first reads high 14*MSG_LEN+1 cycles after the edge that sampled start.
- i==j: both writes target the same address, and the final value is si. This is legal and requires no special case.
- i wraps 255->0 when MSG_LEN reaches 256. j is never reset between bytes.
- S contents persist across runs. i, j and k are cleared on each start.

Test Plan:
- Identity S (S[x]=x), MSG_LEN=2, ROM={0xA5,0x5A}, pulse start -> ram[0]=0xA7, ram[1]=0x5F. Afterwards S[2]=0x03, S[3]=0x02, all other entries unchanged.
- Same run: check finish rises exactly 29 cycles after the start edge, and decrypt_mem_handler falls in the same cycle. s_wen is high for exactly 4 cycles total and ram_wen for exactly 2.
- Wrap case: identity S except S[1]=0xFF, S[255]=0x01; MSG_LEN=1; ROM[0]=0x3C -> j=0xFF, f=S[0x00]=0x00, so ram[0]=0x3C. Afterwards S[1]=0x01, S[255]=0xFF.
- Assert reset during WR_I of byte 0 -> no s_wen or ram_wen afterwards, all outputs 0, finish=0. A new start then reproduces the first scenario's results.
- Pulse start again while busy (for example in WAIT_J) -> ignored; results and cycle count identical to an undisturbed run.
- Random 256-permutation S, MSG_LEN=32, random ROM -> ram contents and final S match a software RC4 PRGA model byte for byte.
